// File: rtl/datapath_seq_pkg.sv
// Shared definitions for the register/ALU datapath: sequencer state codes,
// ALU opcodes and the default datapath width.
package datapath_seq_pkg;

    localparam int DEF_W = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/datapath_seq_if.sv
// Command, datapath-control and response signals between the sequencer
// (slave side) and its environment: command source, registers, ALU, consumer.
interface datapath_seq_if
    import datapath_seq_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [W-1:0]     cmd_a;
    logic [W-1:0]     cmd_b;
    logic             ld_a;
    logic             ld_b;
    logic             ld_r;
    logic [W-1:0]     d_a;
    logic [W-1:0]     d_b;
    logic [1:0]       alu_op;
    logic [W-1:0]     r_q;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, r_q, res_ready,
        output cmd_ready, ld_a, ld_b, ld_r, d_a, d_b, alu_op,
               res_valid, res_data, op_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, r_q, res_ready,
        input  cmd_ready, ld_a, ld_b, ld_r, d_a, d_b, alu_op,
               res_valid, res_data, op_count
    );

endinterface

// File: rtl/datapath_seq_op_counter.sv
// Completed-operation counter: enable, synchronous clear, wraps modulo 2^CNT_W.
module dp_op_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/datapath_seq.sv
// Sequencer for the 4-bit register/ALU datapath: one command in, load pulses
// for A, B and R, then the R value returned on a valid/ready response.
module datapath_seq
    import datapath_seq_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    datapath_seq_if.slave  bus
);

    state_t           r_state;
    logic             r_cmd_ready;
    logic             r_ld_a;
    logic             r_ld_b;
    logic             r_ld_r;
    logic             r_res_valid;
    logic [1:0]       r_cap_op;
    logic [W-1:0]     r_cap_a;
    logic [W-1:0]     r_cap_b;
    logic [1:0]       r_alu_op;
    logic [W-1:0]     r_d_a;
    logic [W-1:0]     r_d_b;
    logic             w_done;
    logic [CNT_W-1:0] w_count;

    // Outputs are registered on leaving a state, so each pulse appears one
    // cycle after its state is entered; RESP raises res_valid on its first edge.
    // NOTE: every state register uses <=, so all branches see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_ld_a      <= 1'b0;
            r_ld_b      <= 1'b0;
            r_ld_r      <= 1'b0;
            r_res_valid <= 1'b0;
            r_cap_op    <= '0;
            r_cap_a     <= '0;
            r_cap_b     <= '0;
            r_alu_op    <= '0;
            r_d_a       <= '0;
            r_d_b       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_cap_op    <= bus.cmd_op;
                        r_cap_a     <= bus.cmd_a;
                        r_cap_b     <= bus.cmd_b;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_ld_a   <= 1'b1;
                    r_ld_b   <= 1'b1;
                    r_d_a    <= r_cap_a;
                    r_d_b    <= r_cap_b;
                    r_alu_op <= r_cap_op;
                    r_state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_ld_a  <= 1'b0;
                    r_ld_b  <= 1'b0;
                    r_ld_r  <= 1'b1;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_ld_r <= 1'b0;
                    if (!r_res_valid) begin
                        r_res_valid <= 1'b1;
                    end else if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_done = (r_state == ST_RESP) && r_res_valid && bus.res_ready;

    dp_op_counter #(.CNT_W(CNT_W)) u_op_counter (
        .clk     (clk),
        .i_clr   (rst),
        .i_en    (w_done),
        .o_count (w_count)
    );

    // R only holds the new result once res_valid is up; mask it otherwise.
    assign bus.res_data  = r_res_valid ? bus.r_q : '0;
    assign bus.cmd_ready = r_cmd_ready;
    assign bus.ld_a      = r_ld_a;
    assign bus.ld_b      = r_ld_b;
    assign bus.ld_r      = r_ld_r;
    assign bus.d_a       = r_d_a;
    assign bus.d_b       = r_d_b;
    assign bus.alu_op    = r_alu_op;
    assign bus.res_valid = r_res_valid;
    assign bus.op_count  = w_count;

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: three 4-bit registers plus a behavioural ALU around
// an 8-bit-counter instance, and a 2-bit-counter instance sharing its stimulus.
module tb_datapath_seq;
    import datapath_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    datapath_seq_if #(.W(4), .CNT_W(8)) bus8();
    datapath_seq_if #(.W(4), .CNT_W(2)) bus2();

    datapath_seq #(.W(4), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    datapath_seq #(.W(4), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    function automatic logic [3:0] alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a | b;
        endcase
    endfunction

    logic [3:0] reg_a, reg_b, reg_r;
    always @(posedge clk) begin
        if (rst) begin
            reg_a <= '0;
            reg_b <= '0;
            reg_r <= '0;
        end else begin
            if (bus8.ld_a) reg_a <= bus8.d_a;
            if (bus8.ld_b) reg_b <= bus8.d_b;
            if (bus8.ld_r) reg_r <= alu(bus8.alu_op, reg_a, reg_b);
        end
    end

    assign bus8.r_q      = reg_r;
    assign bus2.r_q      = reg_r;
    assign bus2.cmd_valid = bus8.cmd_valid;
    assign bus2.cmd_op    = bus8.cmd_op;
    assign bus2.cmd_a     = bus8.cmd_a;
    assign bus2.cmd_b     = bus8.cmd_b;
    assign bus2.res_ready = bus8.res_ready;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; hold > 0 keeps res_ready low that many cycles in RESP.
    task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp, input int hold);
        int n, lat, na, nb, nr;
        n = 0;
        while (!bus8.cmd_ready && n < 10) begin
            tick();
            n++;
        end
        check("ready_before_cmd", bus8.cmd_ready, 1);
        bus8.res_ready = (hold == 0);
        bus8.cmd_op    = op;
        bus8.cmd_a     = a;
        bus8.cmd_b     = b;
        bus8.cmd_valid = 1'b1;
        tick();
        bus8.cmd_valid = 1'b0;
        bus8.cmd_op    = op + 2'd1;
        bus8.cmd_a     = ~a;
        bus8.cmd_b     = ~b;
        check("ready_busy", bus8.cmd_ready, 0);
        lat = 0; na = 0; nb = 0; nr = 0;
        while (!bus8.res_valid && lat < 10) begin
            tick();
            lat++;
            na += int'(bus8.ld_a);
            nb += int'(bus8.ld_b);
            nr += int'(bus8.ld_r);
        end
        check("latency", lat, 3);
        check("ld_a_pulses", na, 1);
        check("ld_b_pulses", nb, 1);
        check("ld_r_pulses", nr, 1);
        check("alu_op_held", bus8.alu_op, op);
        check("res_data", bus8.res_data, exp);
        for (int i = 0; i < hold; i++) begin
            bus8.cmd_valid = (i == 2);
            tick();
            check("bp_valid", bus8.res_valid, 1);
            check("bp_data", bus8.res_data, exp);
            check("bp_ready", bus8.cmd_ready, 0);
            check("bp_no_load", bus8.ld_a, 0);
        end
        bus8.cmd_valid = 1'b0;
        bus8.res_ready = 1'b1;
        tick();
        exp_cnt++;
        check("valid_drop", bus8.res_valid, 0);
        check("ready_rise", bus8.cmd_ready, 1);
        check("op_count", bus8.op_count, exp_cnt);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[5];
    int   wrap_exp[4];

    initial begin
        vecs[0] = '{OP_ADD, 4'b0011, 4'b1011, 4'b1110};
        vecs[1] = '{OP_AND, 4'b1100, 4'b1010, 4'b1000};
        vecs[2] = '{OP_ADD, 4'b1111, 4'b0001, 4'b0000};
        vecs[3] = '{OP_SUB, 4'b0000, 4'b0001, 4'b1111};
        vecs[4] = '{OP_OR,  4'b1010, 4'b0101, 4'b1111};
        wrap_exp = '{1, 2, 3, 0};

        rst = 1'b1;
        bus8.cmd_valid = 1'b0;
        bus8.cmd_op    = '0;
        bus8.cmd_a     = '0;
        bus8.cmd_b     = '0;
        bus8.res_ready = 1'b1;

        // Reset state
        for (int i = 0; i < 5; i++) tick();
        check("rst_cmd_ready", bus8.cmd_ready, 1);
        check("rst_ld", {bus8.ld_a, bus8.ld_b, bus8.ld_r}, 0);
        check("rst_res_valid", bus8.res_valid, 0);
        check("rst_op_count", bus8.op_count, 0);
        check("rst_res_data", bus8.res_data, 0);
        check("rst_fields", {bus8.d_a, bus8.d_b, bus8.alu_op}, 0);
        rst = 1'b0;
        tick();

        // Table of single operations, res_ready tied high (last entry: OR)
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);
        end

        // Backpressure with an ignored command pulse
        run_op(OP_SUB, 4'b1111, 4'b0011, 4'b1100, 6);
        check("bp_count_once", bus8.op_count, 6);

        // Reset during EXEC drops the operation
        bus8.cmd_op    = OP_ADD;
        bus8.cmd_a     = 4'b0001;
        bus8.cmd_b     = 4'b0001;
        bus8.cmd_valid = 1'b1;
        tick();
        bus8.cmd_valid = 1'b0;
        tick();
        check("mid_in_exec", bus8.ld_a, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        check("mid_ld_r", bus8.ld_r, 0);
        check("mid_idle_ready", bus8.cmd_ready, 1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                seen += int'(bus8.res_valid) + int'(bus8.ld_r);
            end
            check("mid_no_response", seen, 0);
        end
        check("mid_op_count", bus8.op_count, 0);

        // Back-to-back AND ops; 2-bit counter wraps
        bus8.cmd_op    = OP_AND;
        bus8.cmd_a     = 4'b1100;
        bus8.cmd_b     = 4'b1010;
        bus8.res_ready = 1'b1;
        bus8.cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int cyc;
            logic [1:0] prev;
            tick();
            check("wrap_accept", bus2.cmd_ready, 0);
            prev = bus2.op_count;
            cyc = 0;
            while (bus2.op_count == prev && cyc < 12) begin
                tick();
                cyc++;
            end
            check("wrap_cycles", cyc, 4);
            check("wrap_count", bus2.op_count, wrap_exp[k]);
            check("wrap_ready", bus2.cmd_ready, 1);
        end
        bus8.cmd_valid = 1'b0;
        check("wrap_wide_count", bus8.op_count, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
